// File: rtl/alarm_pkg.sv
// ============================================================================
// Module   : alarm_pkg
// Purpose  : Shared encodings for the alarm annunciator: alarm bit indices,
//            priority class codes, FSM state enum and a priority helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

  // Bit positions inside the {fire, burglar, rain} alarm vector
  localparam int ALM_FIRE    = 2;
  localparam int ALM_BURGLAR = 1;
  localparam int ALM_RAIN    = 0;

  // Reported class codes, ordered so a numeric compare is a priority compare
  localparam logic [1:0] CLS_NONE    = 2'd0;
  localparam logic [1:0] CLS_RAIN    = 2'd1;
  localparam logic [1:0] CLS_BURGLAR = 2'd2;
  localparam logic [1:0] CLS_FIRE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOUND    = 2'd1,
    ST_SILENCED = 2'd2
  } state_t;

  // Highest-priority class present in a latched vector (fire > burglar > rain)
  function automatic logic [1:0] prio_class(input logic [2:0] bits);
    if (bits[ALM_FIRE])         return CLS_FIRE;
    else if (bits[ALM_BURGLAR]) return CLS_BURGLAR;
    else if (bits[ALM_RAIN])    return CLS_RAIN;
    else                        return CLS_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_annunciator_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Free-running divider producing a one-cycle tick every TICK_DIV
//            clocks; restart forces the count back to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; restart realigns the pattern timebase
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/alarm_annunciator.sv
// ============================================================================
// Module   : alarm_annunciator
// Purpose  : Latches {fire, burglar, rain} alarms, reports the highest class,
//            drives a class-specific siren pattern and a steady strobe, and
//            supports acknowledge/silence with a timed re-arm.
// Options  : ALARM_EVENT_LOG_EN - per-class saturating 8-bit latch counters
//            on event_count; when undefined event_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int TICK_DIV      = 1000,
  parameter int SILENCE_TICKS = 30,
  parameter int RAIN_PERIOD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  alarms,
  input  logic        ack,
  output logic        siren,
  output logic        strobe,
  output logic [1:0]  active_class,
  output logic [2:0]  latched,
  output logic        silenced,
  output logic [23:0] event_count
);

  localparam int            PW    = (RAIN_PERIOD > 1) ? $clog2(RAIN_PERIOD) : 1;
  localparam logic [PW-1:0] PLAST = PW'(RAIN_PERIOD - 1);
  localparam int            SW    = $clog2(SILENCE_TICKS + 1);
  localparam logic [SW-1:0] SLAST = SW'(SILENCE_TICKS - 1);

  state_t        state, state_n;
  logic          ack_q, ack_edge;
  logic [2:0]    clear_mask, latched_n;
  logic [1:0]    sil_class;
  logic [SW-1:0] sil_cnt;
  logic [PW-1:0] phase;
  logic          toggle;
  logic          tick, silence_done, enter_sound, pattern;

  assign ack_edge     = ack & ~ack_q;
  assign silence_done = tick && (sil_cnt == SLAST);
  assign enter_sound  = (state_n == ST_SOUND) && (state != ST_SOUND);
  assign silenced     = (state == ST_SILENCED);

  // Pattern timebase restarts on every entry to SOUND
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (enter_sound),
    .tick    (tick)
  );

  // Sticky alarm bits: ack clears only inputs that are low, so set wins
  always_comb begin
    clear_mask = ack_edge ? ~alarms : 3'b000;
    latched_n  = (latched & ~clear_mask) | alarms;
  end

  // Next-state logic; an ack that empties latched always returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (latched != 3'b000) state_n = ST_SOUND;
      end
      ST_SOUND: begin
        if (ack_edge && !alarms[ALM_FIRE]) state_n = ST_SILENCED;
      end
      ST_SILENCED: begin
        if (prio_class(latched) > sil_class) state_n = ST_SOUND;
        else if (silence_done) state_n = (latched != 3'b000) ? ST_SOUND : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (ack_edge && (latched_n == 3'b000)) state_n = ST_IDLE;
  end

  // State, silence timer and the class that was silenced (for escalation)
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sil_cnt   <= '0;
      sil_class <= CLS_NONE;
    end else begin
      state <= state_n;
      if ((state_n == ST_SILENCED) && (state != ST_SILENCED)) sil_class <= prio_class(latched_n);
      if ((state_n != ST_SILENCED) || (state != ST_SILENCED)) sil_cnt <= '0;
      else if (tick) sil_cnt <= sil_cnt + 1'b1;
    end
  end

  // Latch register, ack edge history and registered priority class
  always_ff @(posedge clk) begin
    if (reset) begin
      latched      <= 3'b000;
      ack_q        <= 1'b0;
      active_class <= CLS_NONE;
    end else begin
      latched      <= latched_n;
      ack_q        <= ack;
      active_class <= prio_class(latched);
    end
  end

  // Pattern phase (rain) and toggle (burglar) advance on ticks while sounding
  always_ff @(posedge clk) begin
    if (reset || enter_sound) begin
      phase  <= '0;
      toggle <= 1'b0;
    end else if ((state == ST_SOUND) && tick) begin
      phase  <= (phase == PLAST) ? '0 : phase + 1'b1;
      toggle <= ~toggle;
    end
  end

  // Class-specific siren waveform
  always_comb begin
    pattern = 1'b0;
    case (active_class)
      CLS_FIRE:    pattern = 1'b1;
      CLS_BURGLAR: pattern = ~toggle;
      CLS_RAIN:    pattern = (phase == '0);
      default:     pattern = 1'b0;
    endcase
  end

  // Registered outputs: siren only while sounding, strobe while any alarm held
  always_ff @(posedge clk) begin
    if (reset) begin
      siren  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      siren  <= (state == ST_SOUND) && pattern;
      strobe <= (active_class != CLS_NONE);
    end
  end

`ifdef ALARM_EVENT_LOG_EN
  for (genvar gi = 0; gi < 3; gi++) begin : g_evt
    logic [7:0] count;
    // Count rising edges of each latched bit, saturating at 255
    always_ff @(posedge clk) begin
      if (reset) begin
        count <= 8'd0;
      end else if (latched_n[gi] && !latched[gi] && (count != 8'hFF)) begin
        count <= count + 8'd1;
      end
    end
    assign event_count[gi*8 +: 8] = count;
  end
`else
  assign event_count = 24'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_annunciator.sv
// ============================================================================
// Module   : tb_alarm_annunciator
// Purpose  : Directed scoreboard bench for alarm_annunciator with
//            TICK_DIV=4, SILENCE_TICKS=3, RAIN_PERIOD=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_annunciator;

`ifdef ALARM_EVENT_LOG_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  localparam logic [7:0] M_SIREN = 8'h80;
  localparam logic [7:0] M_LAT   = 8'h0E;
  localparam logic [7:0] M_SIL   = 8'h01;
  localparam logic [7:0] M_ALL   = 8'hFF;
  localparam logic [7:0] M_NONE  = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  alarms;
  logic        ack;
  logic        siren, strobe, silenced;
  logic [1:0]  active_class;
  logic [2:0]  latched;
  logic [23:0] event_count;
  logic [7:0]  obs;

  alarm_annunciator #(
    .TICK_DIV      (4),
    .SILENCE_TICKS (3),
    .RAIN_PERIOD   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alarms       (alarms),
    .ack          (ack),
    .siren        (siren),
    .strobe       (strobe),
    .active_class (active_class),
    .latched      (latched),
    .silenced     (silenced),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {siren, strobe, active_class, latched, silenced};

  typedef struct packed {
    int          at;
    logic [7:0]  exp;
    logic [7:0]  mask;
    logic        ev_chk;
    logic [23:0] ev;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  exp_t  cur;
  string cur_tag;
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic [7:0] pk(input logic s, input logic st, input logic [1:0] c,
                                    input logic [2:0] l, input logic si);
    return {s, st, c, l, si};
  endfunction

  function automatic void chk(input int at, input logic [7:0] exp, input logic [7:0] mask,
                              input logic ev_chk, input logic [23:0] ev, input string tag);
    exp_t e;
    e.at = at; e.exp = exp; e.mask = mask; e.ev_chk = ev_chk; e.ev = ev;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endfunction

  // Monitor: compare every expectation due at this cycle, away from the edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur     = sb.pop_front();
      cur_tag = sb_tag.pop_front();
      n_checks++;
      if (cur.at != cyc)
        $display("FAIL %s: due at cycle %0d, seen at %0d", cur_tag, cur.at, cyc);
      else if (((obs ^ cur.exp) & cur.mask) != 8'h00)
        $display("FAIL %s @%0d: {siren,strobe,cls,latched,sil} got %b required %b mask %b",
                 cur_tag, cyc, obs, cur.exp, cur.mask);
      else if (cur.ev_chk && (event_count !== cur.ev))
        $display("FAIL %s @%0d: event_count got %h required %h", cur_tag, cyc, event_count, cur.ev);
      else
        n_pass++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, a, b, f, g, x, y, r, s;
    reset = 1'b1; alarms = 3'b000; ack = 1'b0;

    // Reset state
    chk(3, 8'h00, M_ALL, 1'b1, 24'h0, "reset_state");
    go_to(3);
    reset = 1'b0;

    // Rain single-cycle pulse: 4-of-16 beep, then ack with input low
    e = cyc + 1; a = e + 22;
    chk(e, pk(0, 0, 2'd0, 3'b001, 0), M_LAT, 1'b0, 24'h0, "rain_latch");
    chk(e + 1, pk(0, 0, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "rain_class");
    for (int k = e + 2; k <= e + 21; k++)
      chk(k, pk(((k - e - 2) % 16) < 4, 1, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "rain_pattern");
    chk(a, pk(0, 0, 2'd0, 3'b000, 0), M_LAT | M_SIL, 1'b0, 24'h0, "rain_ack_clear");
    chk(a + 1, pk(0, 0, 2'd0, 3'b000, 0), M_SIREN | M_LAT, 1'b0, 24'h0, "rain_ack_siren");
    chk(a + 2, 8'h00, M_ALL, 1'b0, 24'h0, "rain_idle");
    alarms = 3'b001;
    go_to(e); alarms = 3'b000;
    go_to(a - 1); ack = 1'b1;
    go_to(a); ack = 1'b0;
    go_to(a + 3);

    // Burglar pulse: siren toggles every 4 cycles, ack clears to IDLE
    e = cyc + 1; a = e + 14;
    chk(e + 1, pk(0, 0, 2'd2, 3'b010, 0), M_ALL, 1'b0, 24'h0, "burg_class");
    for (int k = e + 2; k <= e + 13; k++)
      chk(k, pk((((k - e - 2) / 4) % 2) == 0, 1, 2'd2, 3'b010, 0), M_ALL, 1'b0, 24'h0, "burg_pattern");
    chk(a, pk(0, 0, 2'd0, 3'b000, 0), M_LAT | M_SIL, 1'b0, 24'h0, "burg_ack_clear");
    chk(a + 1, pk(0, 0, 2'd0, 3'b000, 0), M_SIREN | M_LAT | M_SIL, 1'b0, 24'h0, "burg_siren_off");
    chk(a + 2, 8'h00, M_ALL, 1'b0, 24'h0, "burg_idle");
    alarms = 3'b010;
    go_to(e); alarms = 3'b000;
    go_to(a - 1); ack = 1'b1;
    go_to(a); ack = 1'b0;
    go_to(a + 3);

    // Fire held: ack cannot silence; drop fire then ack clears
    e = cyc + 1; a = e + 5; f = a + 5; g = f + 3;
    chk(e + 1, pk(0, 0, 2'd3, 3'b100, 0), M_ALL, 1'b0, 24'h0, "fire_class");
    for (int k = e + 2; k <= e + 4; k++)
      chk(k, pk(1, 1, 2'd3, 3'b100, 0), M_ALL, 1'b0, 24'h0, "fire_sound");
    for (int k = a; k <= a + 4; k++)
      chk(k, pk(1, 1, 2'd3, 3'b100, 0), M_ALL, 1'b0, 24'h0, "fire_ack_held");
    for (int k = f; k <= f + 2; k++)
      chk(k, pk(1, 1, 2'd3, 3'b100, 0), M_ALL, 1'b0, 24'h0, "fire_dropped");
    chk(g, pk(0, 0, 2'd0, 3'b000, 0), M_LAT | M_SIL, 1'b0, 24'h0, "fire_ack_clear");
    chk(g + 2, 8'h00, M_ALL, 1'b0, 24'h0, "fire_idle");
    alarms = 3'b100;
    go_to(a - 1); ack = 1'b1;
    go_to(a); ack = 1'b0;
    go_to(f - 1); alarms = 3'b000;
    go_to(g - 1); ack = 1'b1;
    go_to(g); ack = 1'b0;
    go_to(g + 3);

    // Rain held: silence for 12 cycles, re-sound, silence again, escalate
    e = cyc + 1; a = e + 5; b = a + 16; x = b + 2; y = x + 4;
    chk(e + 1, pk(0, 0, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "sil_class");
    for (int k = e + 2; k <= e + 4; k++)
      chk(k, pk(1, 1, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "sil_sound");
    chk(a, pk(1, 1, 2'd1, 3'b001, 1), M_ALL, 1'b0, 24'h0, "sil_enter");
    for (int k = a + 1; k <= a + 11; k++)
      chk(k, pk(0, 1, 2'd1, 3'b001, 1), M_ALL, 1'b0, 24'h0, "sil_quiet");
    chk(a + 12, pk(0, 1, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "sil_rearm");
    chk(a + 13, pk(1, 1, 2'd1, 3'b001, 0), M_ALL, 1'b0, 24'h0, "sil_resound");
    chk(b, pk(1, 1, 2'd1, 3'b001, 1), M_ALL, 1'b0, 24'h0, "sil_enter2");
    chk(b + 1, pk(0, 1, 2'd1, 3'b001, 1), M_ALL, 1'b0, 24'h0, "sil_quiet2");
    chk(x, pk(0, 1, 2'd1, 3'b011, 1), M_ALL, 1'b0, 24'h0, "esc_latch");
    chk(x + 1, pk(0, 1, 2'd2, 3'b011, 0), M_ALL, 1'b0, 24'h0, "esc_sound");
    chk(x + 2, pk(1, 1, 2'd2, 3'b011, 0), M_ALL, 1'b0, 24'h0, "esc_siren");
    chk(y, pk(0, 0, 2'd0, 3'b000, 0), M_LAT | M_SIL, 1'b0, 24'h0, "esc_ack_clear");
    chk(y + 2, 8'h00, M_ALL, 1'b0, 24'h0, "esc_idle");
    alarms = 3'b001;
    go_to(a - 1); ack = 1'b1;
    go_to(a); ack = 1'b0;
    go_to(b - 1); ack = 1'b1;
    go_to(b); ack = 1'b0;
    go_to(x - 1); alarms = 3'b011;
    go_to(x); alarms = 3'b000;
    go_to(y - 1); ack = 1'b1;
    go_to(y); ack = 1'b0;
    go_to(y + 3);

    // All alarms at once, then reset in the middle of SOUND
    e = cyc + 1; r = e + 4;
    chk(e, pk(0, 0, 2'd0, 3'b111, 0), M_LAT, 1'b0, 24'h0, "all_latch");
    chk(e + 1, pk(0, 0, 2'd3, 3'b111, 0), M_ALL, 1'b1, EV_EN ? 24'h020303 : 24'h0, "all_class");
    chk(e + 2, pk(1, 1, 2'd3, 3'b111, 0), M_ALL, 1'b0, 24'h0, "all_sound");
    chk(e + 3, pk(1, 1, 2'd3, 3'b111, 0), M_ALL, 1'b0, 24'h0, "all_sound2");
    chk(r, 8'h00, M_ALL, 1'b1, 24'h0, "mid_reset");
    chk(r + 1, 8'h00, M_ALL, 1'b0, 24'h0, "post_reset");
    alarms = 3'b111;
    go_to(e); alarms = 3'b000;
    go_to(r - 1); reset = 1'b1;
    go_to(r); reset = 1'b0;
    go_to(r + 2);

    // 300 rain latch/ack cycles: rain count saturates at 255
    s = cyc;
    chk(s + 300, pk(0, 0, 2'd0, 3'b000, 0), M_LAT, 1'b1, EV_EN ? 24'h000064 : 24'h0, "evlog_100");
    chk(s + 900, pk(0, 0, 2'd0, 3'b000, 0), M_LAT, 1'b1, EV_EN ? 24'h0000FF : 24'h0, "evlog_sat");
    chk(s + 901, 8'h00, M_NONE, 1'b1, EV_EN ? 24'h0000FF : 24'h0, "evlog_hold");
    for (int i = 0; i < 300; i++) begin
      e = s + 3 * i + 1;
      alarms = 3'b001;
      go_to(e); alarms = 3'b000; ack = 1'b1;
      go_to(e + 1); ack = 1'b0;
      go_to(e + 2);
    end
    go_to(s + 904);

    while (sb.size() > 0) begin
      cur     = sb.pop_front();
      cur_tag = sb_tag.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", cur_tag, cur.at, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
